// File: rtl/fru_bitstream_loader.sv
// Serial configuration bitstream loader.
// Hunts for a 16-bit sync word, shifts in a CFG_SIZE-bit payload and an 8-bit
// CRC (poly 0x07, init 0, MSB first), and publishes the payload only when the
// CRC matches. Long valid-low gaps inside a frame abort it.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   SerialIn     serial data, MSB first, sampled when StreamValid is 1
//   StreamValid  qualifies SerialIn
//   ParallelOut  last CRC-verified payload
//   CfgDone      ParallelOut holds a verified frame (state DONE)
//   CfgError     last frame failed CRC or gap check (state ERR)
//   Busy         frame in progress (LOAD, CRC, CHECK)
`timescale 1ns/1ps
module fru_bitstream_loader #(
    parameter int unsigned CFG_SIZE  = 64,
    parameter logic [15:0] SYNC_WORD = 16'hA5C3,
    parameter int unsigned GAP_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SerialIn,
    input  logic                StreamValid,
    output logic [CFG_SIZE-1:0] ParallelOut,
    output logic                CfgDone,
    output logic                CfgError,
    output logic                Busy
);

    localparam int unsigned CNT_W = $clog2(CFG_SIZE + 1);
    localparam int unsigned GAP_W = $clog2(GAP_LIMIT + 2);

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        LOAD  = 3'd1,
        CRC   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t              state, state_d;
    logic [15:0]         window, window_d;
    logic [CFG_SIZE-1:0] shadow, shadow_d;
    logic [CFG_SIZE-1:0] pout_d;
    logic [7:0]          crc_calc, crc_calc_d;
    logic [7:0]          crc_rx, crc_rx_d;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic                done_d, error_d, busy_d;

    logic [15:0] window_shift;
    logic [7:0]  crc_step;
    logic        crc_fb;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state;
        window_d   = window;
        shadow_d   = shadow;
        pout_d     = ParallelOut;
        crc_calc_d = crc_calc;
        crc_rx_d   = crc_rx;
        bit_cnt_d  = bit_cnt;
        gap_cnt_d  = gap_cnt;

        window_shift = {window[14:0], SerialIn};
        crc_fb       = crc_calc[7] ^ SerialIn;
        crc_step     = {crc_calc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

        case (state)
            HUNT, DONE, ERR: begin
                if (StreamValid) begin
                    window_d = window_shift;
                    if (window_shift == SYNC_WORD) begin
                        state_d    = LOAD;
                        window_d   = 16'h0000;
                        crc_calc_d = 8'h00;
                        crc_rx_d   = 8'h00;
                        bit_cnt_d  = '0;
                        gap_cnt_d  = '0;
                    end
                end
            end
            LOAD: begin
                if (StreamValid) begin
                    shadow_d   = {shadow[CFG_SIZE-2:0], SerialIn};
                    crc_calc_d = crc_step;
                    gap_cnt_d  = '0;
                    if (bit_cnt == CNT_W'(CFG_SIZE - 1)) begin
                        state_d   = CRC;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end else if (gap_cnt == GAP_W'(GAP_LIMIT)) begin
                    state_d   = ERR;
                    gap_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            CRC: begin
                if (StreamValid) begin
                    crc_rx_d  = {crc_rx[6:0], SerialIn};
                    gap_cnt_d = '0;
                    if (bit_cnt == CNT_W'(7)) begin
                        state_d   = CHECK;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt + CNT_W'(1);
                    end
                end else if (gap_cnt == GAP_W'(GAP_LIMIT)) begin
                    state_d   = ERR;
                    gap_cnt_d = '0;
                    bit_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt + GAP_W'(1);
                end
            end
            CHECK: begin
                // Only a verified payload ever reaches the output register
                if (crc_rx == crc_calc) begin
                    pout_d  = shadow;
                    state_d = DONE;
                end else begin
                    state_d = ERR;
                end
            end
            default: state_d = HUNT;
        endcase

        // Flags registered from the next state so they track the state register
        done_d  = (state_d == DONE);
        error_d = (state_d == ERR);
        busy_d  = (state_d == LOAD) || (state_d == CRC) || (state_d == CHECK);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            window      <= 16'h0000;
            shadow      <= '0;
            ParallelOut <= '0;
            crc_calc    <= 8'h00;
            crc_rx      <= 8'h00;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            CfgDone     <= 1'b0;
            CfgError    <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state       <= state_d;
            window      <= window_d;
            shadow      <= shadow_d;
            ParallelOut <= pout_d;
            crc_calc    <= crc_calc_d;
            crc_rx      <= crc_rx_d;
            bit_cnt     <= bit_cnt_d;
            gap_cnt     <= gap_cnt_d;
            CfgDone     <= done_d;
            CfgError    <= error_d;
            Busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_fru_bitstream_loader.sv
// Bench for fru_bitstream_loader (CFG_SIZE=16): directed frames, a frame-level
// reference model checked every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_fru_bitstream_loader;

    localparam int unsigned N   = 16;
    localparam int unsigned GAP = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b0;
    logic         vld = 1'b0;
    logic [N-1:0] po;
    logic         done, err, busy;

    int n_cmp = 0;
    int n_bad = 0;

    fru_bitstream_loader #(
        .CFG_SIZE (N),
        .SYNC_WORD(16'hA5C3),
        .GAP_LIMIT(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .SerialIn   (sin),
        .StreamValid(vld),
        .ParallelOut(po),
        .CfgDone    (done),
        .CfgError   (err),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit [15:0]    m_win     = '0;
    bit           m_collect = 1'b0;
    bit           m_pending = 1'b0;
    int           m_gap     = 0;
    int           m_result  = 0;   // 0 none, 1 verified, 2 failed
    bit [N-1:0]   m_po      = '0;
    bit           m_bits[$];

    // Frame is good iff payload||crc is divisible by x^8+x^2+x+1
    function automatic bit frame_ok(input bit q[$]);
        logic [N+7:0] m;
        m = '0;
        foreach (q[i]) m = {m[N+6:0], q[i]};
        for (int i = N + 7; i >= 8; i--)
            if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
        return (m[7:0] == 8'h00);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_win = '0; m_collect = 0; m_pending = 0; m_gap = 0;
            m_result = 0; m_po = '0; m_bits.delete();
        end else if (m_pending) begin
            m_pending = 0;
            if (frame_ok(m_bits)) begin
                m_result = 1;
                for (int i = 0; i < int'(N); i++) m_po = {m_po[N-2:0], m_bits[i]};
            end else begin
                m_result = 2;
            end
        end else if (m_collect) begin
            if (vld) begin
                m_bits.push_back(sin);
                m_gap = 0;
                if (m_bits.size() == N + 8) begin
                    m_collect = 0;
                    m_pending = 1;
                end
            end else begin
                m_gap++;
                if (m_gap == int'(GAP) + 1) begin
                    m_collect = 0;
                    m_result  = 2;
                end
            end
        end else if (vld) begin
            m_win = {m_win[14:0], sin};
            if (m_win == 16'hA5C3) begin
                m_win = '0; m_collect = 1; m_gap = 0; m_result = 0;
                m_bits.delete();
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit eb;
        eb = m_collect | m_pending;
        check("po_model",   32'(po),   32'(m_po));
        check("busy_model", 32'(busy), 32'(eb));
        check("done_model", 32'(done), 32'(!eb && m_result == 1));
        check("err_model",  32'(err),  32'(!eb && m_result == 2));
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0;
        end
    endtask

    task automatic send_bit(input bit b, input int gap);
        idle(gap);
        @(negedge clk);
        vld = 1'b1;
        sin = b;
    endtask

    task automatic send_bits(input logic [31:0] w, input int nb, input int gapmax);
        logic [31:0] v;
        v = w;
        for (int i = nb - 1; i >= 0; i--)
            send_bit(v[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    endtask

    task automatic frame(input logic [15:0] p, input logic [7:0] c, input int gapmax);
        send_bits(32'hA5C3, 16, gapmax);
        send_bits(32'(p), 16, gapmax);
        send_bits(32'(c), 8, gapmax);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_po", 32'(po), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk); #2 rst = 1'b1;

        // Contiguous zero frame with leading noise
        send_bits(32'b011, 3, 0);
        frame(16'h0000, 8'h00, 0);
        idle(1);
        check("t1_check_done", 32'(done), 32'h0);
        check("t1_check_busy", 32'(busy), 32'h1);
        idle(1);
        check("t1_done", 32'(done), 32'h1);
        check("t1_po", 32'(po), 32'h0000);
        check("t1_err", 32'(err), 32'h0);

        // 0001/07 with random gaps and one maximal 255-cycle gap
        send_bits(32'hA5C3, 16, 20);
        send_bits(32'h00, 8, 20);
        send_bit(1'b0, 255);
        send_bits(32'h01, 7, 20);
        send_bits(32'h07, 8, 20);
        idle(2);
        check("t2_done", 32'(done), 32'h1);
        check("t2_po", 32'(po), 32'h0001);

        // Bad CRC keeps previous payload
        frame(16'h0001, 8'h00, 0);
        idle(2);
        check("t3_err", 32'(err), 32'h1);
        check("t3_done", 32'(done), 32'h0);
        check("t3_po", 32'(po), 32'h0001);

        // 256-cycle gap aborts, then good frame 0100/15
        send_bits(32'hA5C3, 16, 0);
        send_bits(32'b10110, 5, 0);
        idle(256);
        check("t4_gap255_busy", 32'(busy), 32'h1);
        idle(1);
        check("t4_gap_err", 32'(err), 32'h1);
        check("t4_gap_busy", 32'(busy), 32'h0);
        frame(16'h0100, 8'h15, 3);
        idle(2);
        check("t4_done", 32'(done), 32'h1);
        check("t4_err", 32'(err), 32'h0);
        check("t4_po", 32'(po), 32'h0100);

        // Reload from DONE: output holds until CHECK
        frame(16'h0001, 8'h07, 0);
        idle(2);
        check("t5_first_po", 32'(po), 32'h0001);
        send_bits(32'hA5C3, 16, 0);
        send_bits(32'h0, 12, 0);
        check("t5_mid_po", 32'(po), 32'h0001);
        check("t5_mid_done", 32'(done), 32'h0);
        send_bits(32'h0, 4, 0);
        send_bits(32'h00, 8, 0);
        idle(1);
        check("t5_check_po", 32'(po), 32'h0001);
        idle(1);
        check("t5_po", 32'(po), 32'h0000);
        check("t5_done", 32'(done), 32'h1);

        // Reset at payload bit 9, then sync-less bits are ignored
        frame(16'h0001, 8'h07, 0);
        idle(2);
        send_bits(32'hA5C3, 16, 0);
        send_bits(32'h1FF, 9, 0);
        @(negedge clk); #2 rst = 1'b0;
        #1;
        check("t6_rst_po", 32'(po), 32'h0);
        check("t6_rst_done", 32'(done), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_err", 32'(err), 32'h0);
        @(negedge clk); #2 rst = 1'b1;
        send_bits(32'hFFFFFF, 24, 0);
        idle(2);
        check("t6_after_busy", 32'(busy), 32'h0);
        check("t6_after_po", 32'(po), 32'h0);
        check("t6_after_done", 32'(done), 32'h0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fru_bitstream_loader.md
FRU_BITSTREAM_LOADER -- requirements
Module: fru_bitstream_loader

Interface
REQ-001 SHALL have parameter CFG_SIZE, default 64, meaning payload width in bits, a multiple of 8 and at least 16.
REQ-002 SHALL have parameter SYNC_WORD, default 16'hA5C3, meaning the frame start pattern.
REQ-003 SHALL have parameter GAP_LIMIT, default 255, meaning the maximum consecutive StreamValid-low cycles allowed inside a frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port SerialIn, input, 1 bit: serial bitstream data, MSB first.
REQ-007 SHALL have port StreamValid, input, 1 bit: SerialIn is sampled only on edges where this is 1.
REQ-008 SHALL have port ParallelOut, output, CFG_SIZE bits: last CRC-verified payload.
REQ-009 SHALL have port CfgDone, output, 1 bit: ParallelOut holds a verified frame.
REQ-010 SHALL have port CfgError, output, 1 bit: last frame failed the CRC or gap check.
REQ-011 SHALL have port Busy, output, 1 bit: high in states LOAD, CRC and CHECK.

Function
REQ-012 SHALL implement states HUNT, LOAD, CRC, CHECK, DONE and ERR.
REQ-013 HUNT: each valid bit SHALL shift into a 16-bit window; when the window after the shift equals SYNC_WORD, the next state SHALL be LOAD and the window SHALL clear.
REQ-014 LOAD: each valid bit SHALL shift into a payload shadow register and increment a bit counter; when the CFG_SIZE-th bit is accepted, the next state SHALL be CRC and the counter SHALL clear.
REQ-015 CRC-8 SHALL be computed bit-serially over the payload bits only, using polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
REQ-016 CRC: exactly 8 valid bits SHALL be accepted as the received CRC, MSB first; after the 8th, the next state SHALL be CHECK.
REQ-017 CHECK (exactly one cycle): on a match, ParallelOut SHALL load the shadow register and the next state SHALL be DONE; on a mismatch, ParallelOut SHALL be unchanged and the next state SHALL be ERR.
REQ-018 Done latency: CfgDone SHALL be 1 on the second rising edge after the edge that samples the last CRC bit.
REQ-019 ParallelOut SHALL change only in CHECK on a match; partial or failed frames SHALL never be visible.
REQ-020 In LOAD and CRC, a gap counter SHALL count consecutive StreamValid-low cycles and clear on any valid bit; when it reaches GAP_LIMIT+1, the next state SHALL be ERR.
REQ-021 Valid-low cycles SHALL NOT alter the window, shadow register, CRC or counters, except the gap counter.
REQ-022 CfgDone SHALL be 1 only in DONE, and CfgError 1 only in ERR.
REQ-023 DONE and ERR SHALL keep hunting exactly as in HUNT; on a sync match, the next state SHALL be LOAD and CfgDone/CfgError SHALL drop.
REQ-024 In DONE, ParallelOut SHALL hold its value through the new frame until that frame's CHECK.
REQ-025 Sync-pattern bits arriving during LOAD or CRC SHALL be treated as data; there SHALL be no resynchronisation mid-frame.
REQ-026 Payload MSB SHALL be the first payload bit received.

Reset
REQ-027 With rst low, asynchronously: state HUNT, ParallelOut all zeros, CfgDone 0, CfgError 0, Busy 0, and window, shadow, CRC and counters zero.
REQ-028 Reset asserted mid-frame SHALL discard the frame, clear ParallelOut, and require a new sync word.

Verification (CFG_SIZE=16)
REQ-029 Bench SHALL cover: A5C3, payload 0000, CRC 00, contiguous -> CfgDone=1 on the 2nd edge after the last bit; ParallelOut=16'h0000; CfgError=0.
REQ-030 Bench SHALL cover: A5C3, payload 0001, CRC 07, with random valid gaps each < 255 -> CfgDone=1; ParallelOut=16'h0001.
REQ-031 Bench SHALL cover: A5C3, payload 0001, CRC 00 -> CfgError=1, CfgDone=0, ParallelOut keeps its prior value.
REQ-032 Bench SHALL cover: a 256-cycle valid-low gap mid-payload -> ERR; then a good frame -> DONE, CfgError=0.
REQ-033 Bench SHALL cover: DONE with 0001, then a new frame 0000 with CRC 00 -> ParallelOut stays 0001 until CHECK, then 0000; CfgDone low during reload.
REQ-034 Bench SHALL cover: rst pulsed low at payload bit 9 -> all outputs zero immediately; bits without a sync word are ignored.
